// File: rtl/sbm_operand_loader_pkg.sv
// sbm_operand_loader_pkg
// Shared definitions for the multiplier operand loader: FSM state encoding
// and helpers that derive word counts and the word-counter width from the
// operand and stream widths.
package sbm_operand_loader_pkg;

   // Loader FSM states
   typedef enum logic [1:0] {
      ST_LOAD_A = 2'd0,
      ST_LOAD_B = 2'd1,
      ST_HOLD   = 2'd2
   } state_t;

   // Number of stream words that make up one operand
   function automatic int unsigned words_of(input int unsigned size,
                                            input int unsigned digits);
      return size / digits;
   endfunction

   // Word counter width: enough to index the larger operand, plus one bit
   function automatic int unsigned cnt_width(input int unsigned words_a,
                                             input int unsigned words_b);
      return $clog2((words_a > words_b) ? words_a : words_b) + 1;
   endfunction

endpackage

// File: rtl/sbm_operand_loader_if.sv
// sbm_operand_loader_if
// Bundles the word stream (din/din_valid/din_ready/clear) and the operand
// presentation handshake (a_out/b_out/op_valid/op_ack) of the loader.
// master: the side feeding words and acknowledging operands.
// slave:  the loader itself.
interface sbm_operand_loader_if #(
   parameter int SIZEA         = 1024,
   parameter int SIZEB         = 1024,
   parameter int SIZEOF_DIGITS = 32
);

   logic [SIZEOF_DIGITS-1:0] din;
   logic                     din_valid;
   logic                     din_ready;
   logic                     clear;
   logic [SIZEA-1:0]         a_out;
   logic [SIZEB-1:0]         b_out;
   logic                     op_valid;
   logic                     op_ack;

   modport master (
      output din,
      output din_valid,
      output clear,
      output op_ack,
      input  din_ready,
      input  a_out,
      input  b_out,
      input  op_valid
   );

   modport slave (
      input  din,
      input  din_valid,
      input  clear,
      input  op_ack,
      output din_ready,
      output a_out,
      output b_out,
      output op_valid
   );

endinterface

// File: rtl/sbm_operand_loader_word_slot_writer.sv
// sbm_word_slot_writer
// Holds one operand register and writes a single stream word into the slot
// selected by the loader's word counter. All other slots keep their value.
// Word order is selected at build time by SBM_LOADER_MSW_FIRST_EN:
//   defined   - word k lands in slot WORDS-1-k (most-significant first)
//   undefined - word k lands in slot k (least-significant first)
module sbm_word_slot_writer
   import sbm_operand_loader_pkg::*;
#(
   parameter int SIZE          = 1024,
   parameter int SIZEOF_DIGITS = 32,
   parameter int CNT_W         = 6
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [CNT_W-1:0]         idx,
   input  logic [SIZEOF_DIGITS-1:0] word,
   output logic [SIZE-1:0]          operand
);

   localparam int unsigned WORDS = words_of(SIZE, SIZEOF_DIGITS);

   logic [CNT_W-1:0] slot_s;
   logic [SIZE-1:0]  op_r;

   // Map the arrival index of a word onto its slot in the operand
   always_comb begin
      slot_s = '0;
`ifdef SBM_LOADER_MSW_FIRST_EN
      slot_s = CNT_W'(WORDS - 1) - idx;
`else
      slot_s = idx;
`endif
   end

   // Write the accepted word into its slot; other slots are left untouched
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_r <= '0;
      end else begin
         for (int k = 0; k < int'(WORDS); k++) begin
            if (wr_en && (slot_s == CNT_W'(k))) begin
               op_r[k*SIZEOF_DIGITS +: SIZEOF_DIGITS] <= word;
            end
         end
      end
   end

   assign operand = op_r;

endmodule

// File: rtl/sbm_operand_loader.sv
// sbm_operand_loader
// Upstream feeder for the digit-serial multiplier. Assembles operands A and B
// from a stream of SIZEOF_DIGITS-bit words and presents them as stable,
// registered buses under a valid/ack handshake. din_ready and op_valid are
// registered FSM outputs, so neither depends combinationally on din_valid or
// op_ack. clear aborts the current load synchronously without zeroing the
// operand registers.
// Build option: SBM_LOADER_MSW_FIRST_EN selects most-significant-word-first
// placement (handled inside sbm_word_slot_writer).
module sbm_operand_loader
   import sbm_operand_loader_pkg::*;
#(
   parameter int SIZEA         = 1024,
   parameter int SIZEB         = 1024,
   parameter int SIZEOF_DIGITS = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   sbm_operand_loader_if.slave  bus
);

   localparam int unsigned WORDS_A = words_of(SIZEA, SIZEOF_DIGITS);
   localparam int unsigned WORDS_B = words_of(SIZEB, SIZEOF_DIGITS);
   localparam int unsigned CNT_W   = cnt_width(WORDS_A, WORDS_B);

   state_t           state_r;
   logic [CNT_W-1:0] cnt_r;
   logic             din_ready_r;
   logic             op_valid_r;

   logic             xfer_s;
   logic             last_a_s;
   logic             last_b_s;
   logic             wr_a_s;
   logic             wr_b_s;

   // Transfer qualification and per-operand write enables; clear drops the word
   always_comb begin
      xfer_s   = 1'b0;
      last_a_s = 1'b0;
      last_b_s = 1'b0;
      wr_a_s   = 1'b0;
      wr_b_s   = 1'b0;
      xfer_s   = bus.din_valid & din_ready_r;
      last_a_s = (cnt_r == CNT_W'(WORDS_A - 1));
      last_b_s = (cnt_r == CNT_W'(WORDS_B - 1));
      if (bus.clear) begin
         wr_a_s = 1'b0;
         wr_b_s = 1'b0;
      end else begin
         wr_a_s = xfer_s & (state_r == ST_LOAD_A);
         wr_b_s = xfer_s & (state_r == ST_LOAD_B);
      end
   end

   // Load sequencing FSM with registered handshake outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= ST_LOAD_A;
         cnt_r       <= '0;
         din_ready_r <= 1'b1;
         op_valid_r  <= 1'b0;
      end else if (bus.clear) begin
         state_r     <= ST_LOAD_A;
         cnt_r       <= '0;
         din_ready_r <= 1'b1;
         op_valid_r  <= 1'b0;
      end else begin
         case (state_r)
            ST_LOAD_A: begin
               if (xfer_s) begin
                  if (last_a_s) begin
                     state_r <= ST_LOAD_B;
                     cnt_r   <= '0;
                  end else begin
                     cnt_r   <= cnt_r + CNT_W'(1);
                  end
               end
            end
            ST_LOAD_B: begin
               if (xfer_s) begin
                  if (last_b_s) begin
                     state_r     <= ST_HOLD;
                     cnt_r       <= '0;
                     din_ready_r <= 1'b0;
                     op_valid_r  <= 1'b1;
                  end else begin
                     cnt_r       <= cnt_r + CNT_W'(1);
                  end
               end
            end
            ST_HOLD: begin
               if (bus.op_ack) begin
                  state_r     <= ST_LOAD_A;
                  cnt_r       <= '0;
                  din_ready_r <= 1'b1;
                  op_valid_r  <= 1'b0;
               end
            end
            default: begin
               state_r     <= ST_LOAD_A;
               cnt_r       <= '0;
               din_ready_r <= 1'b1;
               op_valid_r  <= 1'b0;
            end
         endcase
      end
   end

   sbm_word_slot_writer #(
      .SIZE          (SIZEA),
      .SIZEOF_DIGITS (SIZEOF_DIGITS),
      .CNT_W         (CNT_W)
   ) u_slot_a (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_a_s),
      .idx     (cnt_r),
      .word    (bus.din),
      .operand (bus.a_out)
   );

   sbm_word_slot_writer #(
      .SIZE          (SIZEB),
      .SIZEOF_DIGITS (SIZEOF_DIGITS),
      .CNT_W         (CNT_W)
   ) u_slot_b (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_b_s),
      .idx     (cnt_r),
      .word    (bus.din),
      .operand (bus.b_out)
   );

   assign bus.din_ready = din_ready_r;
   assign bus.op_valid  = op_valid_r;

endmodule

// File: tb/tb_sbm_operand_loader.sv
// tb_sbm_operand_loader
// Randomized stimulus with a scoreboard: the driver updates a word-level
// reference model on every accepted word and queues the expected operand
// pair when a load completes; a monitor pops and compares whenever op_valid
// is high. Honours SBM_LOADER_MSW_FIRST_EN when defined.
module tb_sbm_operand_loader;
   import sbm_operand_loader_pkg::*;

   localparam int SIZEA = 1024;
   localparam int SIZEB = 1024;
   localparam int D     = 32;
   localparam int WA    = SIZEA / D;
   localparam int WB    = SIZEB / D;
   localparam int W     = (SIZEA > SIZEB) ? SIZEA : SIZEB;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   sbm_operand_loader_if #(.SIZEA(SIZEA), .SIZEB(SIZEB), .SIZEOF_DIGITS(D)) bus ();

   sbm_operand_loader #(.SIZEA(SIZEA), .SIZEB(SIZEB), .SIZEOF_DIGITS(D)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [SIZEB-1:0] b;
      logic [SIZEA-1:0] a;
   } ops_t;

   ops_t             exp_q[$];
   logic [SIZEA-1:0] mdl_a;
   logic [SIZEB-1:0] mdl_b;
   int               mdl_phase;   // 0: loading A, 1: loading B, 2: holding
   int               mdl_idx;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk_wide(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      int bad;
      bad = -1;
      checks++;
      for (int i = W/D - 1; i >= 0; i--) begin
         if (act[i*D +: D] !== exp[i*D +: D]) bad = i;
      end
      if (bad >= 0) begin
         errors++;
         $display("FAIL %s: word %0d got 0x%0h expected 0x%0h at %0t",
                  nm, bad, act[bad*D +: D], exp[bad*D +: D], $time);
      end
   endtask

   // Slot a word of arrival index k occupies in an operand of 'words' words
   function automatic int slot_of(input int k, input int words);
`ifdef SBM_LOADER_MSW_FIRST_EN
      return words - 1 - k;
`else
      return k;
`endif
   endfunction

   // Reference model: effect of one accepted word (or a clear) on the operands
   task automatic model_xfer(input logic [D-1:0] w, input bit clr);
      if (clr) begin
         mdl_phase = 0;
         mdl_idx   = 0;
      end else if (mdl_phase == 0) begin
         mdl_a[slot_of(mdl_idx, WA)*D +: D] = w;
         if (mdl_idx == WA - 1) begin
            mdl_phase = 1;
            mdl_idx   = 0;
         end else begin
            mdl_idx++;
         end
      end else if (mdl_phase == 1) begin
         mdl_b[slot_of(mdl_idx, WB)*D +: D] = w;
         if (mdl_idx == WB - 1) begin
            exp_q.push_back({mdl_b, mdl_a});
            mdl_phase = 2;
            mdl_idx   = 0;
         end else begin
            mdl_idx++;
         end
      end
   endtask

   // Present one word for a cycle while loading; it must be accepted
   task automatic send_word(input logic [D-1:0] w, input bit clr, input bit ack);
      bus.din       = w;
      bus.din_valid = 1'b1;
      bus.clear     = clr;
      bus.op_ack    = ack;
      @(negedge clk);
      chk("din_ready_load", bus.din_ready, 64'd1);
      chk("op_valid_load", bus.op_valid, 64'd0);
      @(posedge clk);
      #1;
      model_xfer(w, clr);
      bus.din_valid = 1'b0;
      bus.clear     = 1'b0;
      bus.op_ack    = 1'b0;
      bus.din       = $urandom;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         bus.din = $urandom;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic load(input int n, input int clear_at, input int ack_at,
                       input bit gaps, input bit incr, input bit first_a5);
      logic [D-1:0] w;
      for (int k = 0; k < n; k++) begin
         w = incr ? D'(k) : D'($urandom);
         if (k == 0 && first_a5) w = 32'hA5A5A5A5;
         if (gaps && $urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
         send_word(w, k == clear_at, k == ack_at);
      end
   endtask

   // Sit in hold (optionally offering words), then acknowledge
   task automatic hold_and_ack(input int stall, input bit present);
      for (int i = 0; i < stall; i++) begin
         bus.din_valid = present;
         bus.din       = $urandom;
         @(negedge clk);
         chk("din_ready_hold", bus.din_ready, 64'd0);
         chk("op_valid_hold", bus.op_valid, 64'd1);
         @(posedge clk);
         #1;
      end
      bus.din_valid = 1'b0;
      bus.op_ack    = 1'b1;
      @(negedge clk);
      chk("op_valid_ack_cycle", bus.op_valid, 64'd1);
      @(posedge clk);
      #1;
      bus.op_ack = 1'b0;
      mdl_phase  = 0;
      mdl_idx    = 0;
      chk("din_ready_after_ack", bus.din_ready, 64'd1);
      chk("op_valid_after_ack", bus.op_valid, 64'd0);
   endtask

   // Scoreboard monitor: compare presented operands against queued expectations
   ops_t cur;
   bit   have_cur = 1'b0;
   always @(negedge clk) begin
      if (rst) begin
         have_cur = 1'b0;
      end else if (bus.op_valid) begin
         if (!have_cur) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb_unexpected_op_valid: got 1 expected 0 at %0t", $time);
            end else begin
               cur      = exp_q.pop_front();
               have_cur = 1'b1;
            end
         end
         if (have_cur) begin
            chk_wide("a_out", W'(bus.a_out), W'(cur.a));
            chk_wide("b_out", W'(bus.b_out), W'(cur.b));
         end
      end else begin
         have_cur = 1'b0;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.din       = '0;
      bus.din_valid = 1'b0;
      bus.clear     = 1'b0;
      bus.op_ack    = 1'b0;
      mdl_a         = '0;
      mdl_b         = '0;
      mdl_phase     = 0;
      mdl_idx       = 0;
      rst           = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      chk("rst_din_ready", bus.din_ready, 64'd1);
      chk("rst_op_valid", bus.op_valid, 64'd0);
      chk_wide("rst_a_out", W'(bus.a_out), '0);
      chk_wide("rst_b_out", W'(bus.b_out), '0);

      // Back-to-back incrementing load
      load(WA + WB, -1, -1, 1'b0, 1'b1, 1'b0);
`ifdef SBM_LOADER_MSW_FIRST_EN
      chk("b2b_a_lsw", bus.a_out[31:0], 64'h1F);
      chk("b2b_a_msw", bus.a_out[SIZEA-1 -: 32], 64'h0);
      chk("b2b_b_lsw", bus.b_out[31:0], 64'h3F);
      chk("b2b_b_msw", bus.b_out[SIZEB-1 -: 32], 64'h20);
`else
      chk("b2b_a_lsw", bus.a_out[31:0], 64'h0);
      chk("b2b_a_msw", bus.a_out[SIZEA-1 -: 32], 64'h1F);
      chk("b2b_b_lsw", bus.b_out[31:0], 64'h20);
      chk("b2b_b_msw", bus.b_out[SIZEB-1 -: 32], 64'h3F);
`endif
      hold_and_ack(10, 1'b1);

      // Random load with gaps, first A word fixed, stray ack during B
      load(WA + WB, -1, 40, 1'b1, 1'b0, 1'b1);
`ifdef SBM_LOADER_MSW_FIRST_EN
      chk("first_word_slot", bus.a_out[SIZEA-1 -: 32], 64'hA5A5A5A5);
`else
      chk("first_word_slot", bus.a_out[31:0], 64'hA5A5A5A5);
`endif
      hold_and_ack(2, 1'b1);

      // Clear together with word 40, then a fresh full load
      load(41, 40, -1, 1'b1, 1'b0, 1'b0);
      chk("clear_din_ready", bus.din_ready, 64'd1);
      chk("clear_op_valid", bus.op_valid, 64'd0);
      load(WA + WB, -1, -1, 1'b1, 1'b0, 1'b0);
      hold_and_ack(0, 1'b0);

      // Asynchronous reset in the middle of a load
      load(20, -1, -1, 1'b1, 1'b0, 1'b0);
      #3 rst = 1'b1;
      #1;
      chk("arst_din_ready", bus.din_ready, 64'd1);
      chk("arst_op_valid", bus.op_valid, 64'd0);
      chk_wide("arst_a_out", W'(bus.a_out), '0);
      chk_wide("arst_b_out", W'(bus.b_out), '0);
      mdl_a     = '0;
      mdl_b     = '0;
      mdl_phase = 0;
      mdl_idx   = 0;
      @(posedge clk);
      #1 rst = 1'b0;
      load(WA + WB, -1, -1, 1'b1, 1'b0, 1'b0);
      hold_and_ack(3, 1'b1);

      // A few more random loads
      for (int r = 0; r < 3; r++) begin
         load(WA + WB, -1, -1, 1'b1, 1'b0, 1'b0);
         hold_and_ack($urandom_range(0, 4), 1'b1);
      end

      idle(2);
      chk("sb_drained", 64'(exp_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sbm_operand_loader.md
# sbm_operand_loader

Upstream feeder for the digit-serial multiplier. Accepts operands as a stream of `SIZEOF_DIGITS`-bit words with a valid/ready handshake and assembles them into full-width `a` and `b` registers. Once both operands are complete it presents them as stable, registered buses with a valid/ack handshake. The multiplier consumes `a_out`/`b_out` directly while `op_valid` is high.

## Interface
Parameters:
- `SIZEA`, 1024, width of operand A in bits
- `SIZEB`, 1024, width of operand B in bits
- `SIZEOF_DIGITS`, 32, stream word width; `SIZEA` and `SIZEB` are integer multiples of it

Ports:
- `clk`  in  1  single clock; all logic on the rising edge
- `rst`  in  1  asynchronous, active-high reset
- `din`  in  SIZEOF_DIGITS  stream word
- `din_valid`  in  1  `din` is valid this cycle
- `din_ready`  out  1  loader accepts a word this cycle
- `clear`  in  1  synchronous abort of the current load
- `a_out`  out  SIZEA  assembled operand A, registered
- `b_out`  out  SIZEB  assembled operand B, registered
- `op_valid`  out  1  `a_out`/`b_out` are complete and stable
- `op_ack`  in  1  consumer has taken the operands

## Operation
- Derived constants: `WORDS_A = SIZEA/SIZEOF_DIGITS` and `WORDS_B = SIZEB/SIZEOF_DIGITS` (32 each at the defaults). The word counter is `$clog2(max(WORDS_A, WORDS_B))+1` bits wide.
- FSM states:
  - ST_LOAD_A: `din_ready=1`.
  - ST_LOAD_B: `din_ready=1`.
  - ST_HOLD: `din_ready=0`, `op_valid=1`.
- A transfer happens on any cycle with `din_valid & din_ready`. Word k of an operand is written to bits `[k*SIZEOF_DIGITS +: SIZEOF_DIGITS]`. All other bits keep their value.
- Transitions:
  - ST_LOAD_A → ST_LOAD_B on the transfer of word `WORDS_A-1`; the counter returns to 0.
  - ST_LOAD_B → ST_HOLD on the transfer of word `WORDS_B-1`.
  - ST_HOLD → ST_LOAD_A when `op_ack=1`; the counter returns to 0.
- `op_ack` outside ST_HOLD is ignored.
- `clear` takes priority over everything else. From any state it forces the next state to ST_LOAD_A, counter to 0 and `op_valid` to 0. A word presented in the same cycle is dropped. `a_out`/`b_out` are not zeroed.
- Operand registers are only written during a transfer. They stay stable for the whole time ST_HOLD lasts, and after it until overwritten.
- Asserting `rst` mid-load drops any partial operand.

## Timing
- Reset values:
  - state ST_LOAD_A, counter 0
  - `din_ready=1`, `op_valid=0`
  - `a_out=0`, `b_out=0`
- `din_ready` and `op_valid` are decoded from registered state only. There is no combinational path from `din_valid` or `op_ack`.
- Latency: `op_valid` rises in the cycle after the last B transfer. Minimum is `WORDS_A+WORDS_B` transfer cycles plus 1 (65 cycles at the defaults).
- After `op_ack` in cycle t: `op_valid=0` and `din_ready=1` from cycle t+1. The earliest new A word is accepted at t+1.
- `din_valid` gaps stall the loader without loss. `din_valid` while `din_ready=0` is not a transfer.

## Configuration
- `SBM_LOADER_MSW_FIRST_EN`:
  - Defined: the first word of each operand goes to the most-significant slot. Word k lands at index `WORDS-1-k`.
  - Undefined: least-significant word first, as described above.
  - The handshake, counts and latency are identical in both modes.

## Structure
- Shared package holds the state encoding constants (ST_LOAD_A=0, ST_LOAD_B=1, ST_HOLD=2) and the derived-word-count helper function.
- One sub-module, `sbm_word_slot_writer`: given the counter value, operand width and the order macro, it writes one word into an operand register. It is instantiated once for A and once for B.

## Test plan
- Reset:
  - Stimulus: assert `rst` asynchronously mid-cycle.
  - Response: immediately `din_ready=1`, `op_valid=0`, `a_out=b_out=0`.
- Back-to-back load:
  - Stimulus: 64 words `0x00000000..0x0000003F` with `din_valid` held high.
  - Response: `op_valid` at cycle 65; `a_out[31:0]=0`, `a_out[1023:992]=0x1F`, `b_out[31:0]=0x20`, `b_out[1023:992]=0x3F`.
- Stalls and hold:
  - Stimulus: random `din_valid` gaps; in ST_HOLD, drive `op_ack` low for 10 cycles while presenting words.
  - Response: `din_ready=0`, no words consumed, outputs stable; after `op_ack`, `din_ready=1` next cycle.
- Clear:
  - Stimulus: `clear` together with the transfer of word 40.
  - Response: word dropped, state ST_LOAD_A; a fresh 64-word load completes normally.
- MSW-first:
  - Stimulus: with `SBM_LOADER_MSW_FIRST_EN` defined, send `0xA5A5A5A5` as the first A word.
  - Response: `a_out[1023:992]=0xA5A5A5A5`.
- Stray ack:
  - Stimulus: `op_ack` pulsed during ST_LOAD_B.
  - Response: no effect; the load continues to ST_HOLD.
